// File: rtl/uart_tx_buffer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer_pkg
//   Shared types and defaults for the UART transmit buffer and its FIFO.
//   - UART_BYTE_W         : width of one UART payload byte
//   - TX_*_DEFAULT        : default FIFO depth, pointer width, synchronizer depth
//   - uart_byte_t         : one payload byte
//   - tx_state_t          : start-sequencer states
// -----------------------------------------------------------------------------
package uart_tx_buffer_pkg;

  localparam int UART_BYTE_W         = 8;
  localparam int TX_DEPTH_DEFAULT    = 16;
  localparam int TX_ADDR_W_DEFAULT   = 4;
  localparam int TX_SYNC_STG_DEFAULT = 2;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer_if
//   Bundles the producer push port, the FIFO status and the transmitter
//   handshake of uart_tx_buffer.
//   slave  : view of the buffer itself (takes pushes, drives tx_data/tx_start)
//   master : view of the surroundings (producers plus the UART transmitter)
//   Signals:
//     wr_data/wr_en                  producer push
//     full/empty/count/overflow      FIFO status (registered)
//     tx_data/tx_start               byte and start level to the transmitter
//     tx_free/tx_done                transmitter status (tx_clock domain)
//     byte_sent                      one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
interface uart_tx_buffer_if
  import uart_tx_buffer_pkg::*;
#(
  parameter int ADDR_W = TX_ADDR_W_DEFAULT
) ();

  uart_byte_t        wr_data;
  logic              wr_en;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  uart_byte_t        tx_data;
  logic              tx_start;
  logic              tx_free;
  logic              tx_done;
  logic              byte_sent;

  modport slave (
    input  wr_data, wr_en, tx_free, tx_done,
    output full, empty, count, overflow, tx_data, tx_start, byte_sent
  );

  modport master (
    output wr_data, wr_en, tx_free, tx_done,
    input  full, empty, count, overflow, tx_data, tx_start, byte_sent
  );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock first-word-fall-through byte FIFO, shared by the TX and RX
//   paths of the UART.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push, push_data write request and byte
//     pop             consume the head entry (ignored while empty)
//     head            current head entry, valid while !empty
//     full, empty     registered occupancy flags
//     count           registered occupancy, 0..DEPTH
//     overflow        sticky: a push arrived while full with no pop
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH  = TX_DEPTH_DEFAULT,
  parameter int ADDR_W = TX_ADDR_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  uart_byte_t      push_data,
  input  logic            pop,
  output uart_byte_t      head,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow
);

  uart_byte_t        mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              full_q,   full_d;
  logic              empty_q,  empty_d;
  logic              overflow_q, overflow_d;

  logic              push_ok;
  logic              pop_ok;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally), so no latch can be inferred.
  always_comb begin
    // Pointers are exactly ADDR_W bits wide, so wrap modulo DEPTH is free.
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop_ok);
    count_d    = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    full_d     = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (push && !push_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // A byte written this cycle only reaches head after the edge, so a pop in
  // the same cycle always sees the older entry.
  assign head     = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//   Byte queue and start sequencer in front of the UART transmitter.
//   Producers push bytes at main_clock rate; the buffer hands them one at a
//   time to the transmitter, pacing on the transmitter's tx_free/tx_done.
//   Ports:
//     main_clock  system clock, rising edge
//     reset_all   synchronous active-high reset
//     bus         uart_tx_buffer_if.slave: push port, FIFO status,
//                 tx_data/tx_start out, tx_free/tx_done in, byte_sent pulse
// -----------------------------------------------------------------------------
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH    = TX_DEPTH_DEFAULT,
  parameter int ADDR_W   = TX_ADDR_W_DEFAULT,
  parameter int SYNC_STG = TX_SYNC_STG_DEFAULT
) (
  input  logic             main_clock,
  input  logic             reset_all,
  uart_tx_buffer_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Synchronizers for the transmitter status (tx_clock domain)
  // ---------------------------------------------------------------------------
  logic [SYNC_STG-1:0] free_sync_q, free_sync_d;
  logic [SYNC_STG-1:0] done_sync_q, done_sync_d;
  logic                done_prev_q, done_prev_d;
  logic                free_s;
  logic                done_s;
  logic                done_r;

  assign free_s = free_sync_q[SYNC_STG-1];
  assign done_s = done_sync_q[SYNC_STG-1];
  // Rise detect: tx_done may stay high for several main_clock cycles.
  assign done_r = done_s && !done_prev_q;

  always_comb begin
    free_sync_d = {free_sync_q[SYNC_STG-2:0], bus.tx_free};
    done_sync_d = {done_sync_q[SYNC_STG-2:0], bus.tx_done};
    done_prev_d = done_s;
  end

  always_ff @(posedge main_clock) begin
    if (reset_all) begin
      free_sync_q <= '0;
      done_sync_q <= '0;
      done_prev_q <= 1'b0;
    end else begin
      free_sync_q <= free_sync_d;
      done_sync_q <= done_sync_d;
      done_prev_q <= done_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  tx_state_t  state_q;
  uart_byte_t tx_data_q;
  logic       tx_start_q;
  logic       byte_sent_q;

  uart_byte_t fifo_head;
  logic       fifo_empty;
  logic       pop;

  // Pop only when leaving IDLE; the registered empty flag guarantees a byte
  // pushed into an empty FIFO is not taken in the cycle it is written.
  assign pop = (state_q == IDLE) && !fifo_empty && free_s;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (main_clock),
    .rst       (reset_all),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (bus.full),
    .empty     (fifo_empty),
    .count     (bus.count),
    .overflow  (bus.overflow)
  );

  assign bus.empty = fifo_empty;

  // ---------------------------------------------------------------------------
  // Start sequencer
  //   IDLE  -> LOAD  : byte popped into tx_data
  //   LOAD  -> START : raise tx_start one cycle after tx_data settles
  //   START -> BUSY  : transmitter accepted (free_s low), drop tx_start
  //   BUSY  -> IDLE  : frame done (done_r or free_s back high), pulse byte_sent
  // tx_data is only written on the IDLE->LOAD transition, so it stays put for
  // the whole frame and until the next byte is loaded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clock) begin
    if (reset_all) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      byte_sent_q <= 1'b0;
    end else begin
      byte_sent_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q <= fifo_head;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          tx_start_q <= 1'b1;
          state_q    <= START;
        end
        START: begin
          if (!free_s) begin
            tx_start_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Both events in one cycle still produce a single pulse.
          if (done_r || free_s) begin
            byte_sent_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.byte_sent = byte_sent_q;

endmodule
